// File: rtl/cache_2way_wt_pkg.sv
// ============================================================================
// Module      : cache_2way_wt_pkg
// Description : Shared line geometry, FSM state encoding and byte-select
//               helper for the 2-way write-through cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_2way_wt_pkg;

   localparam int OFFSET_W = 2;
   localparam int LINE_W   = 32;
   localparam int BYTE_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REFILL = 2'd2
   } state_t;

   // Pick byte 'off' out of a one-word line (byte 0 in the low bits).
   function automatic logic [BYTE_W-1:0] line_byte(input logic [LINE_W-1:0]   line,
                                                   input logic [OFFSET_W-1:0] off);
      return line[{off, 3'b000} +: BYTE_W];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cache_2way_wt_way.sv
// ============================================================================
// Module      : cache_2way_wt_way
// Description : One way of the cache: valid/tag/data flop arrays with a
//               combinational read at the addressed set, a byte-write port
//               for write hits and a whole-line fill port for refills.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_2way_wt_way
   import cache_2way_wt_pkg::*;
#(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 5
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  index,
   input  logic                fill_en,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [LINE_W-1:0]   fill_data,
   input  logic                byte_en,
   input  logic [OFFSET_W-1:0] byte_off,
   input  logic [BYTE_W-1:0]   byte_data,
   output logic                valid,
   output logic [TAG_W-1:0]    tag,
   output logic [LINE_W-1:0]   data
);

   localparam int SETS = 2**INDEX_W;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   // Valid bits are the only array state that reset clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[index] <= 1'b1;
      end
   end

   // Tag/data storage: a fill writes the whole line, a write hit patches one byte.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[index]  <= fill_tag;
         data_q[index] <= fill_data;
      end else if (byte_en) begin
         data_q[index][{byte_off, 3'b000} +: BYTE_W] <= byte_data;
      end
   end

   assign valid = valid_q[index];
   assign tag   = tag_q[index];
   assign data  = data_q[index];

endmodule

`default_nettype wire

// File: rtl/cache_2way_wt.sv
// ============================================================================
// Module      : cache_2way_wt
// Description : 2-way set-associative, write-through, write-no-allocate byte
//               cache with per-set LRU replacement and saturating hit/miss
//               statistics counters. One-word (4-byte) lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_2way_wt
   import cache_2way_wt_pkg::*;
#(
   parameter int ADDR_W  = 13,
   parameter int INDEX_W = 6,
   parameter int CNT_W   = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_from_cpu,
   input  logic              rreq_from_cpu,
   input  logic              wreq_from_cpu,
   input  logic [7:0]        wdata_from_cpu,
   input  logic [31:0]       rdata_from_mem,
   input  logic              rvalid_from_mem,
   output logic [7:0]        rdata_to_cpu,
   output logic              hit_to_cpu,
   output logic              rreq_to_mem,
   output logic [ADDR_W-1:0] raddr_to_mem,
   output logic              wreq_to_mem,
   output logic [ADDR_W-1:0] waddr_to_mem,
   output logic [7:0]        wdata_to_mem,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int SETS  = 2**INDEX_W;

   state_t              state;
   logic [ADDR_W-1:0]   req_addr;
   logic [7:0]          req_wdata;
   logic                req_write;
   logic [SETS-1:0]     lru;          // per set: the way to evict next

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_off;

   logic [1:0]          way_valid;
   logic [TAG_W-1:0]    way_tag  [2];
   logic [LINE_W-1:0]   way_data [2];
   logic [1:0]          way_fill;
   logic [1:0]          way_bwr;

   logic                hit0;
   logic                hit1;
   logic                hit;
   logic                hit_way;
   logic                victim;

   assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
   assign req_index = req_addr[OFFSET_W +: INDEX_W];
   assign req_off   = req_addr[OFFSET_W-1:0];

   generate
      for (genvar w = 0; w < 2; w++) begin : g_way
         cache_2way_wt_way #(
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W)
         ) u_way (
            .clk       (clk),
            .reset     (reset),
            .index     (req_index),
            .fill_en   (way_fill[w]),
            .fill_tag  (req_tag),
            .fill_data (rdata_from_mem),
            .byte_en   (way_bwr[w]),
            .byte_off  (req_off),
            .byte_data (req_wdata),
            .valid     (way_valid[w]),
            .tag       (way_tag[w]),
            .data      (way_data[w])
         );
      end
   endgenerate

   // Tag compare, hit way and victim choice (invalid way first, way0 preferred, else LRU).
   always_comb begin
      hit0    = way_valid[0] && (way_tag[0] == req_tag);
      hit1    = way_valid[1] && (way_tag[1] == req_tag);
      hit     = hit0 || hit1;
      hit_way = !hit0;
      if (!way_valid[0]) begin
         victim = 1'b0;
      end else if (!way_valid[1]) begin
         victim = 1'b1;
      end else begin
         victim = lru[req_index];
      end
   end

   // CPU completion strobe and array write enables, all decoded from the current state.
   always_comb begin
      hit_to_cpu   = (state == ST_LOOKUP) && (req_write || hit);
      rdata_to_cpu = '0;
      if (hit_to_cpu && !req_write) begin
         rdata_to_cpu = line_byte(way_data[hit_way], req_off);
      end
      way_bwr[0]  = (state == ST_LOOKUP) && req_write && hit0;
      way_bwr[1]  = (state == ST_LOOKUP) && req_write && hit1;
      way_fill[0] = (state == ST_REFILL) && rvalid_from_mem && !victim;
      way_fill[1] = (state == ST_REFILL) && rvalid_from_mem && victim;
   end

   // Control FSM with registered memory-side outputs, LRU and statistics counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         req_addr     <= '0;
         req_wdata    <= '0;
         req_write    <= 1'b0;
         lru          <= '0;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
         rreq_to_mem  <= 1'b0;
         raddr_to_mem <= '0;
         wreq_to_mem  <= 1'b0;
         waddr_to_mem <= '0;
         wdata_to_mem <= '0;
      end else begin
         wreq_to_mem <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (wreq_from_cpu || rreq_from_cpu) begin
                  req_addr  <= addr_from_cpu;
                  req_wdata <= wdata_from_cpu;
                  req_write <= wreq_from_cpu;
                  state     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (req_write) begin
                  // Write-through always; the cache copy is only patched on a hit.
                  wreq_to_mem  <= 1'b1;
                  waddr_to_mem <= req_addr;
                  wdata_to_mem <= req_wdata;
                  if (hit) begin
                     lru[req_index] <= !hit_way;
                     if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
                  end else begin
                     if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
                  end
                  state <= ST_IDLE;
               end else if (hit) begin
                  lru[req_index] <= !hit_way;
                  if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
                  state <= ST_IDLE;
               end else begin
                  if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
                  rreq_to_mem  <= 1'b1;
                  raddr_to_mem <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  state        <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               // The fill itself happens in the way arrays; the re-lookup then hits.
               if (rvalid_from_mem) begin
                  rreq_to_mem <= 1'b0;
                  state       <= ST_LOOKUP;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_2way_wt.sv
// ============================================================================
// Module      : tb_cache_2way_wt
// Description : Scoreboard bench for cache_2way_wt. A reference model (resident
//               lines per set in recency order plus a flat word memory) predicts
//               every response; monitors pop and compare DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_2way_wt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (CNT_W=16)
   logic        reset;
   logic [12:0] addr_from_cpu;
   logic        rreq_from_cpu, wreq_from_cpu;
   logic [7:0]  wdata_from_cpu;
   logic [31:0] rdata_from_mem;
   logic        rvalid_from_mem;
   logic [7:0]  rdata_to_cpu;
   logic        hit_to_cpu, rreq_to_mem, wreq_to_mem;
   logic [12:0] raddr_to_mem, waddr_to_mem;
   logic [7:0]  wdata_to_mem;
   logic [15:0] hit_cnt, miss_cnt;

   // small-counter instance (CNT_W=2)
   logic [12:0] s_addr;
   logic        s_rreq, s_wreq, s_rvalid;
   logic [7:0]  s_wdata, s_rdata_to_cpu, s_wdata_to_mem;
   logic [31:0] s_rdata_from_mem;
   logic        s_hit, s_rreq_to_mem, s_wreq_to_mem;
   logic [12:0] s_raddr_to_mem, s_waddr_to_mem;
   logic [1:0]  s_hit_cnt, s_miss_cnt;

   cache_2way_wt #(.ADDR_W(13), .INDEX_W(6), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .addr_from_cpu(addr_from_cpu),
      .rreq_from_cpu(rreq_from_cpu), .wreq_from_cpu(wreq_from_cpu),
      .wdata_from_cpu(wdata_from_cpu), .rdata_from_mem(rdata_from_mem),
      .rvalid_from_mem(rvalid_from_mem), .rdata_to_cpu(rdata_to_cpu),
      .hit_to_cpu(hit_to_cpu), .rreq_to_mem(rreq_to_mem), .raddr_to_mem(raddr_to_mem),
      .wreq_to_mem(wreq_to_mem), .waddr_to_mem(waddr_to_mem), .wdata_to_mem(wdata_to_mem),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   cache_2way_wt #(.ADDR_W(13), .INDEX_W(6), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .addr_from_cpu(s_addr),
      .rreq_from_cpu(s_rreq), .wreq_from_cpu(s_wreq),
      .wdata_from_cpu(s_wdata), .rdata_from_mem(s_rdata_from_mem),
      .rvalid_from_mem(s_rvalid), .rdata_to_cpu(s_rdata_to_cpu),
      .hit_to_cpu(s_hit), .rreq_to_mem(s_rreq_to_mem), .raddr_to_mem(s_raddr_to_mem),
      .wreq_to_mem(s_wreq_to_mem), .waddr_to_mem(s_waddr_to_mem), .wdata_to_mem(s_wdata_to_mem),
      .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: actual=event required=none at %0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          is_write;
      logic [7:0]  rdata;
      logic [15:0] hits;
      logic [15:0] misses;
   } exp_t;
   typedef struct {
      logic [12:0] addr;
      logic [7:0]  data;
   } wr_t;

   exp_t        sb_q[$];
   wr_t         wr_q[$];
   logic [12:0] ra_q[$];

   logic [31:0] ref_mem [2048];
   logic [4:0]  lines   [64][2];   // [0] least recent, [1] most recent
   int          line_cnt[64];
   int          m_hits = 0;
   int          m_miss = 0;

   bit resp_en = 1'b1;
   int fixed_delay = -1;

   // Returns 1 when the line is resident (and makes it most recent);
   // on a miss with alloc set, inserts it, dropping the least recent.
   function automatic bit model_access(input int s, input logic [4:0] t, input bit alloc);
      for (int i = 0; i < line_cnt[s]; i++) begin
         if (lines[s][i] == t) begin
            if (line_cnt[s] == 2 && i == 0) begin
               lines[s][0] = lines[s][1];
               lines[s][1] = t;
            end
            return 1'b1;
         end
      end
      if (alloc) begin
         if (line_cnt[s] < 2) begin
            lines[s][line_cnt[s]] = t;
            line_cnt[s]++;
         end else begin
            lines[s][0] = lines[s][1];
            lines[s][1] = t;
         end
      end
      return 1'b0;
   endfunction

   task automatic do_req(input bit wr, input bit rd, input logic [12:0] a, input logic [7:0] wd);
      exp_t        e;
      wr_t         wt;
      bit          hit;
      int          n;
      logic [31:0] w;
      e.is_write = wr;
      e.rdata    = 8'h00;
      w          = ref_mem[a[12:2]];
      if (wr) begin
         hit = model_access(int'(a[7:2]), a[12:8], 1'b0);
         if (hit) m_hits++;
         else     m_miss++;
         wt.addr = a;
         wt.data = wd;
         wr_q.push_back(wt);
         w[a[1:0]*8 +: 8] = wd;
         ref_mem[a[12:2]] = w;
      end else begin
         hit = model_access(int'(a[7:2]), a[12:8], 1'b1);
         if (!hit) begin
            m_miss++;
            ra_q.push_back({a[12:2], 2'b00});
         end
         m_hits++;
         e.rdata = w[a[1:0]*8 +: 8];
      end
      e.hits   = m_hits[15:0];
      e.misses = m_miss[15:0];
      sb_q.push_back(e);

      @(negedge clk);
      addr_from_cpu  = a;
      wdata_from_cpu = wd;
      wreq_from_cpu  = wr;
      rreq_from_cpu  = rd;
      @(posedge clk);
      #1;
      // scramble the non-request inputs once the request is latched
      addr_from_cpu  = 13'($urandom);
      wdata_from_cpu = 8'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!hit_to_cpu && n < 200);
      if (!hit_to_cpu) begin
         report_unexpected("timeout_waiting_hit");
      end else if (hit) begin
         check("hit_latency", n, 1);
      end
      @(posedge clk);
      #1;
      rreq_from_cpu = 1'b0;
      wreq_from_cpu = 1'b0;
   endtask

   // ---------------- monitor: CPU responses, counters, write-through ----------------
   initial begin : monitor
      exp_t e;
      exp_t last;
      wr_t  wt;
      bit   cnt_due;
      cnt_due = 1'b0;
      forever begin
         @(negedge clk);
         if (cnt_due) begin
            check("hit_cnt", hit_cnt, last.hits);
            check("miss_cnt", miss_cnt, last.misses);
            cnt_due = 1'b0;
         end
         if (hit_to_cpu) begin
            if (sb_q.size() == 0) begin
               report_unexpected("unexpected_hit_to_cpu");
            end else begin
               e = sb_q.pop_front();
               if (!e.is_write) check("rdata_to_cpu", rdata_to_cpu, e.rdata);
               last    = e;
               cnt_due = 1'b1;
            end
         end
         if (wreq_to_mem) begin
            if (wr_q.size() == 0) begin
               report_unexpected("unexpected_wreq_to_mem");
            end else begin
               wt = wr_q.pop_front();
               check("waddr_to_mem", waddr_to_mem, wt.addr);
               check("wdata_to_mem", wdata_to_mem, wt.data);
            end
         end
      end
   end

   // ---------------- memory responder ----------------
   initial begin : responder
      logic [12:0] ra;
      int          d;
      rvalid_from_mem = 1'b0;
      rdata_from_mem  = '0;
      forever begin
         @(negedge clk);
         if (resp_en && rreq_to_mem) begin
            ra = raddr_to_mem;
            if (ra_q.size() == 0) report_unexpected("unexpected_rreq_to_mem");
            else                  check("raddr_to_mem", ra, ra_q.pop_front());
            d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            rdata_from_mem  = ref_mem[ra[12:2]];
            rvalid_from_mem = 1'b1;
            @(negedge clk);
            rvalid_from_mem = 1'b0;
            rdata_from_mem  = $urandom;
         end else if (resp_en && $urandom_range(0, 7) == 0) begin
            // stray pulse while no refill is pending: must be ignored
            rdata_from_mem  = $urandom;
            rvalid_from_mem = 1'b1;
            @(negedge clk);
            rvalid_from_mem = 1'b0;
         end
      end
   end

   // small-instance transaction: returns read byte and the write-through pulse seen
   task automatic s_txn(input bit wr, input bit rd, input logic [12:0] a, input logic [7:0] wd,
                        output logic [7:0] rb, output logic w1, output logic [12:0] wa,
                        output logic [7:0] wdv, output logic w2);
      int n;
      @(negedge clk);
      s_addr = a; s_wdata = wd; s_wreq = wr; s_rreq = rd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         s_rvalid = s_rreq_to_mem && !s_rvalid;
      end while (!s_hit && n < 100);
      s_rvalid = 1'b0;
      if (!s_hit) report_unexpected("s_timeout_waiting_hit");
      rb = s_rdata_to_cpu;
      @(posedge clk);
      #1;
      s_rreq = 1'b0; s_wreq = 1'b0;
      @(negedge clk);
      w1 = s_wreq_to_mem; wa = s_waddr_to_mem; wdv = s_wdata_to_mem;
      @(negedge clk);
      w2 = s_wreq_to_mem;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int          n;
      int          r;
      logic [12:0] a;
      logic [7:0]  rb, wdv;
      logic [12:0] wa;
      logic        w1, w2;

      for (int i = 0; i < 2048; i++) ref_mem[i] = $urandom;
      ref_mem[13'h0104 >> 2] = 32'hDDCCBBAA;
      for (int i = 0; i < 64; i++) line_cnt[i] = 0;

      reset = 1'b1;
      addr_from_cpu = '0; rreq_from_cpu = 1'b0; wreq_from_cpu = 1'b0; wdata_from_cpu = '0;
      s_addr = '0; s_rreq = 1'b0; s_wreq = 1'b0; s_wdata = '0; s_rvalid = 1'b0;
      s_rdata_from_mem = 32'h44332211;
      repeat (2) @(negedge clk);
      check("reset_hit_to_cpu", hit_to_cpu, 0);
      check("reset_rreq_to_mem", rreq_to_mem, 0);
      check("reset_wreq_to_mem", wreq_to_mem, 0);
      check("reset_raddr_to_mem", raddr_to_mem, 0);
      check("reset_hit_cnt", hit_cnt, 0);
      check("reset_miss_cnt", miss_cnt, 0);
      reset = 1'b0;
      @(negedge clk);

      // directed: cold miss, hit, LRU eviction, write-through
      fixed_delay = 3;
      do_req(1'b0, 1'b1, 13'h0104, 8'h00);
      do_req(1'b0, 1'b1, 13'h0105, 8'h00);
      do_req(1'b0, 1'b1, 13'h0204, 8'h00);
      do_req(1'b0, 1'b1, 13'h0304, 8'h00);
      do_req(1'b0, 1'b1, 13'h0204, 8'h00);
      do_req(1'b0, 1'b1, 13'h0104, 8'h00);
      do_req(1'b1, 1'b0, 13'h0106, 8'h5A);
      do_req(1'b0, 1'b1, 13'h0106, 8'h00);
      do_req(1'b1, 1'b0, 13'h1F00, 8'hC3);
      do_req(1'b0, 1'b1, 13'h1F00, 8'h00);
      do_req(1'b1, 1'b1, 13'h0105, 8'h96);
      do_req(1'b0, 1'b1, 13'h0105, 8'h00);

      // randomized traffic over a few tags/sets to force hits, evictions and write misses
      fixed_delay = -1;
      for (int k = 0; k < 300; k++) begin
         a = {3'b000, 2'($urandom_range(0, 3)), 4'b0000, 2'($urandom_range(0, 3)), 2'($urandom)};
         r = int'($urandom_range(0, 7));
         if (r < 5)      do_req(1'b0, 1'b1, a, 8'($urandom));
         else if (r < 7) do_req(1'b1, 1'b0, a, 8'($urandom));
         else            do_req(1'b1, 1'b1, a, 8'($urandom));
      end
      repeat (3) @(negedge clk);

      // reset in the middle of a refill
      resp_en = 1'b0;
      @(negedge clk);
      addr_from_cpu = 13'h0A04;
      rreq_from_cpu = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rreq_to_mem && n < 50);
      check("refill_started", rreq_to_mem, 1);
      #1 reset = 1'b1;
      #1;
      check("midrefill_rreq_to_mem", rreq_to_mem, 0);
      check("midrefill_hit_cnt", hit_cnt, 0);
      check("midrefill_miss_cnt", miss_cnt, 0);
      rreq_from_cpu = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rdata_from_mem  = 32'hFFFFFFFF;
      rvalid_from_mem = 1'b1;
      @(negedge clk);
      rvalid_from_mem = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("late_rvalid_hit_to_cpu", hit_to_cpu, 0);
         check("late_rvalid_rreq_to_mem", rreq_to_mem, 0);
      end
      for (int i = 0; i < 64; i++) line_cnt[i] = 0;
      m_hits = 0;
      m_miss = 0;
      resp_en = 1'b1;
      do_req(1'b0, 1'b1, 13'h0104, 8'h00);
      repeat (3) @(negedge clk);

      // saturating counters on the CNT_W=2 instance
      s_txn(1'b0, 1'b1, 13'h0000, 8'h00, rb, w1, wa, wdv, w2);
      check("s_first_read", rb, 8'h11);
      for (int k = 0; k < 5; k++) begin
         s_txn(1'b0, 1'b1, 13'(k % 4), 8'h00, rb, w1, wa, wdv, w2);
         check("s_read_hit", rb, 8'(32'h44332211 >> ((k % 4) * 8)));
      end
      check("s_hit_cnt_sat", s_hit_cnt, 2'd3);
      check("s_miss_cnt_one", s_miss_cnt, 2'd1);
      s_txn(1'b1, 1'b1, 13'h0002, 8'h77, rb, w1, wa, wdv, w2);
      check("s_both_wreq_pulse", w1, 1);
      check("s_both_waddr", wa, 13'h0002);
      check("s_both_wdata", wdv, 8'h77);
      check("s_wreq_pulse_end", w2, 0);
      s_txn(1'b0, 1'b1, 13'h0002, 8'h00, rb, w1, wa, wdv, w2);
      check("s_read_after_write", rb, 8'h77);
      check("s_hit_cnt_stuck", s_hit_cnt, 2'd3);
      s_txn(1'b0, 1'b1, 13'h0100, 8'h00, rb, w1, wa, wdv, w2);
      s_txn(1'b0, 1'b1, 13'h0200, 8'h00, rb, w1, wa, wdv, w2);
      s_txn(1'b0, 1'b1, 13'h0300, 8'h00, rb, w1, wa, wdv, w2);
      check("s_miss_cnt_sat", s_miss_cnt, 2'd3);

      // every predicted event must have been consumed
      check("sb_queue_empty", sb_q.size(), 0);
      check("wr_queue_empty", wr_q.size(), 0);
      check("raddr_queue_empty", ra_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
